// File: rtl/jts16_region_mapper.sv
// Region decoder with DTACK/BERR generation for a 68000 bus, REGIONS programmable windows.
// Latency: active is combinational; DTACK after (wait+1) cpu_cen ticks, BERR after TIMEOUT ticks.
// Backpressure: none; the CPU is held by withholding DTACK until the window's wait/ack completes.
//
// Ports: clk/rst (async active-high); cpu_cen, addr, cpu_asn, cpu_rnw, cpu_fc, edack from the CPU
// side; cfg_we/cfg_addr/cfg_din/cfg_dout register port (even index = ctrl, odd = base);
// active one-hot chip selects; cpu_dtackn/cpu_berrn registered acks; wp_hit write-protect pulse.
module jts16_region_mapper #(
    parameter int REGIONS = 8,
    parameter int AW      = 23,
    parameter int TIMEOUT = 64,
    parameter int CAW     = $clog2(REGIONS) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cpu_cen,
    input  logic [AW:1]        addr,
    input  logic               cpu_asn,
    input  logic               cpu_rnw,
    input  logic [2:0]         cpu_fc,
    input  logic               edack,
    input  logic               cfg_we,
    input  logic [CAW-1:0]     cfg_addr,
    input  logic [7:0]         cfg_din,
    output logic [7:0]         cfg_dout,
    output logic [REGIONS-1:0] active,
    output logic               cpu_dtackn,
    output logic               cpu_berrn,
    output logic               wp_hit
);
    localparam int IW = CAW - 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, WAIT, ACK, ERR} state_t;

    logic [7:0]         base_q [REGIONS];
    logic [7:0]         ctrl_q [REGIONS];
    logic [7:0]         top;
    logic [REGIONS-1:0] hit;
    logic [REGIONS-1:0] win_oh;
    logic               win_vld;
    logic [7:0]         win_ctrl;
    logic               unused_addr;

    state_t         state;
    logic [2:0]     cnt;
    logic [TW-1:0]  tmo;
    logic [TW-1:0]  tmo_inc;
    logic           ext_mode;
    logic           miss_mode;

    // Only the top byte of the address takes part in the decode.
    assign top         = addr[AW:AW-7];
    assign unused_addr = ^addr[AW-8:1];

    // Larger windows ignore the low bits of the top byte.
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        case (size)
            2'd0:    size_mask = 8'hFF;
            2'd1:    size_mask = 8'hFE;
            2'd2:    size_mask = 8'hF8;
            default: size_mask = 8'hE0;
        endcase
    endfunction

    // Walking downwards leaves the lowest hitting index as the winner.
    always_comb begin
        hit      = '0;
        win_oh   = '0;
        win_vld  = 1'b0;
        win_ctrl = 8'h00;
        for (int i = 0; i < REGIONS; i++) begin
            hit[i] = ctrl_q[i][7] &&
                     (((top ^ base_q[i]) & size_mask(ctrl_q[i][1:0])) == 8'h00);
        end
        for (int i = REGIONS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                win_oh    = '0;
                win_oh[i] = 1'b1;
                win_vld   = 1'b1;
                win_ctrl  = ctrl_q[i];
            end
        end
    end

    // A write to a protected window still gets DTACK, but no chip select, so it is dropped.
    always_comb begin
        if (cpu_asn || cpu_fc == 3'b111 || (!cpu_rnw && win_ctrl[5]))
            active = '0;
        else
            active = win_oh;
    end

    always_comb begin
        cfg_dout = 8'h00;
        for (int i = 0; i < REGIONS; i++) begin
            if (cfg_addr[CAW-1:1] == IW'(i))
                cfg_dout = cfg_addr[0] ? base_q[i] : ctrl_q[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REGIONS; i++) begin
                base_q[i] <= 8'h00;
                ctrl_q[i] <= (i == 0) ? 8'h80 : 8'h00;
            end
        end else if (cfg_we) begin
            for (int i = 0; i < REGIONS; i++) begin
                if (cfg_addr[CAW-1:1] == IW'(i)) begin
                    if (cfg_addr[0]) base_q[i] <= cfg_din;
                    else             ctrl_q[i] <= cfg_din;
                end
            end
        end
    end

    assign tmo_inc = tmo + 1'b1;

    // Wait count and mode are latched at the start of a cycle, so config writes
    // made mid-cycle only affect the next access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cpu_dtackn <= 1'b1;
            cpu_berrn  <= 1'b1;
            wp_hit     <= 1'b0;
            cnt        <= 3'd0;
            tmo        <= '0;
            ext_mode   <= 1'b0;
            miss_mode  <= 1'b0;
        end else begin
            wp_hit <= 1'b0;
            if (cpu_asn) begin
                state      <= IDLE;
                cpu_dtackn <= 1'b1;
                cpu_berrn  <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        // Interrupt acknowledge cycles are left to other logic.
                        if (cpu_fc != 3'b111) begin
                            state     <= WAIT;
                            tmo       <= '0;
                            cnt       <= win_ctrl[4:2];
                            ext_mode  <= (win_ctrl[4:2] == 3'd7);
                            miss_mode <= !win_vld;
                            wp_hit    <= win_vld && win_ctrl[5] && !cpu_rnw;
                        end
                    end
                    WAIT: begin
                        if (cpu_cen) begin
                            if (tmo != TMAX) tmo <= tmo_inc;
                            if (miss_mode) begin
                                if (tmo_inc == TMAX) begin
                                    state     <= ERR;
                                    cpu_berrn <= 1'b0;
                                end
                            end else if (ext_mode) begin
                                if (edack) begin
                                    state      <= ACK;
                                    cpu_dtackn <= 1'b0;
                                end else if (tmo_inc == TMAX) begin
                                    state     <= ERR;
                                    cpu_berrn <= 1'b0;
                                end
                            end else if (cnt == 3'd0) begin
                                state      <= ACK;
                                cpu_dtackn <= 1'b0;
                            end else begin
                                cnt <= cnt - 3'd1;
                            end
                        end
                    end
                    ACK:     cpu_dtackn <= 1'b0;
                    default: cpu_berrn  <= 1'b0;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_jts16_region_mapper.sv
module tb_jts16_region_mapper;
    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_cen = 1'b0;
    logic [23:1] addr;
    logic        cpu_asn;
    logic        cpu_rnw;
    logic [2:0]  cpu_fc;
    logic        edack;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [7:0]  cfg_din;
    logic [7:0]  cfg_dout;
    logic [7:0]  active;
    logic        cpu_dtackn;
    logic        cpu_berrn;
    logic        wp_hit;

    int checks = 0;
    int errors = 0;
    int div    = 0;

    typedef struct {
        logic [7:0] act;
        int         kind;   // 0 = no response, 1 = DTACK, 2 = BERR
        int         cen;
        logic       wp;
    } exp_t;
    exp_t exp_q[$];

    jts16_region_mapper #(.REGIONS(8), .AW(23), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .cpu_cen(cpu_cen), .addr(addr), .cpu_asn(cpu_asn),
        .cpu_rnw(cpu_rnw), .cpu_fc(cpu_fc), .edack(edack), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_din(cfg_din), .cfg_dout(cfg_dout), .active(active),
        .cpu_dtackn(cpu_dtackn), .cpu_berrn(cpu_berrn), .wp_hit(wp_hit)
    );

    always #5 clk = ~clk;

    // cen is high at every 4th rising edge; changed on the falling edge.
    always @(negedge clk) begin
        div     = (div + 1) % 4;
        cpu_cen = (div == 0);
    end

    task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_din = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic release_bus();
        @(negedge clk);
        cpu_asn = 1'b1; edack = 1'b0; cpu_fc = 3'b101; cpu_rnw = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (cpu_dtackn !== 1'b1 || cpu_berrn !== 1'b1) begin
            errors++;
            $display("FAIL release: dtackn=%b berrn=%b, need 1/1", cpu_dtackn, cpu_berrn);
        end
    endtask

    task automatic do_access(input logic [7:0] top, input logic rnw, input logic [2:0] fc,
                             input int edack_at, input logic [7:0] e_act, input int e_kind,
                             input int e_cen, input logic e_wp);
        exp_t e;
        logic act_obs, wp_obs, wp_extra, c;
        logic [7:0] act_v;
        int n, kind;
        exp_q.push_back('{act: e_act, kind: e_kind, cen: e_cen, wp: e_wp});
        @(negedge clk);
        addr = {top, 15'd0}; cpu_rnw = rnw; cpu_fc = fc; cpu_asn = 1'b0; edack = 1'b0;
        #1 act_v = active;
        @(posedge clk); #1;
        wp_obs = wp_hit;
        wp_extra = 1'b0;
        n = 0; kind = 0;
        while (kind == 0 && n < 80) begin
            @(posedge clk);
            c = cpu_cen;
            #1;
            if (c) n++;
            if (wp_hit) wp_extra = 1'b1;
            if (!cpu_dtackn) kind = 1;
            else if (!cpu_berrn) kind = 2;
            if (edack_at > 1 && c && n == edack_at - 1) edack = 1'b1;
        end
        e = exp_q.pop_front();
        act_obs = (act_v === e.act);
        checks++;
        if (!act_obs) begin
            errors++; $display("FAIL active top=%h: got %h need %h", top, act_v, e.act);
        end
        checks++;
        if (wp_obs !== e.wp || wp_extra) begin
            errors++; $display("FAIL wp_hit top=%h: got %b (late %b) need %b", top, wp_obs, wp_extra, e.wp);
        end
        checks++;
        if (kind != e.kind) begin
            errors++; $display("FAIL resp kind top=%h: got %0d need %0d", top, kind, e.kind);
        end else if (kind != 0) begin
            checks++;
            if (n != e.cen) begin
                errors++; $display("FAIL resp cen top=%h: got %0d need %0d", top, n, e.cen);
            end
        end
        if (kind == 2) begin
            repeat (40) @(posedge clk);
            #1;
            checks++;
            if (cpu_berrn !== 1'b0) begin
                errors++; $display("FAIL berr hold: got %b need 0", cpu_berrn);
            end
        end
        release_bus();
    endtask

    task automatic test_reset();
        rst = 1'b1; cpu_asn = 1'b1; cpu_rnw = 1'b1; cpu_fc = 3'b101; edack = 1'b0;
        addr = '0; cfg_we = 1'b0; cfg_addr = 4'd0; cfg_din = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 4'd0; cfg_din = 8'h00;   // must be ignored under reset
        @(posedge clk); #1;
        checks++;
        if (cfg_dout !== 8'h80) begin
            errors++; $display("FAIL reset ctrl0: got %h need 80", cfg_dout);
        end
        checks++;
        if (cpu_dtackn !== 1'b1 || cpu_berrn !== 1'b1 || wp_hit !== 1'b0 || active !== 8'h00) begin
            errors++; $display("FAIL reset outs: dtackn=%b berrn=%b wp=%b act=%h need 1 1 0 00",
                               cpu_dtackn, cpu_berrn, wp_hit, active);
        end
        cfg_we = 1'b0;
        @(negedge clk); rst = 1'b0;
        cfg_addr = 4'd1; #1;
        checks++;
        if (cfg_dout !== 8'h00) begin
            errors++; $display("FAIL reset base0: got %h need 00", cfg_dout);
        end
        cfg_addr = 4'd2; #1;
        checks++;
        if (cfg_dout !== 8'h00) begin
            errors++; $display("FAIL reset ctrl1: got %h need 00", cfg_dout);
        end
    endtask

    task automatic test_default_read();
        do_access(8'h00, 1'b1, 3'b101, 0, 8'h01, 1, 1, 1'b0);
    endtask

    task automatic test_waits();
        cfg_write(4'd6, 8'h8C);
        cfg_write(4'd7, 8'h40);
        cfg_write(4'd0, 8'h00);
        cfg_addr = 4'd6; #1;
        checks++;
        if (cfg_dout !== 8'h8C) begin
            errors++; $display("FAIL readback ctrl3: got %h need 8c", cfg_dout);
        end
        do_access(8'h40, 1'b1, 3'b101, 0, 8'h08, 1, 4, 1'b0);
    endtask

    task automatic test_overlap();
        int k;
        cfg_write(4'd2, 8'h80); cfg_write(4'd3, 8'h20);
        cfg_write(4'd4, 8'h80); cfg_write(4'd5, 8'h20);
        @(negedge clk);
        addr = {8'h20, 15'd0}; cpu_rnw = 1'b1; cpu_fc = 3'b101; cpu_asn = 1'b0;
        #1;
        checks++;
        if (active !== 8'h02) begin
            errors++; $display("FAIL overlap low wins: got %h need 02", active);
        end
        cfg_write(4'd2, 8'h00);
        #1;
        checks++;
        if (active !== 8'h04) begin
            errors++; $display("FAIL overlap after disable: got %h need 04", active);
        end
        k = 0;
        while (cpu_dtackn !== 1'b0 && k < 100) begin
            @(posedge clk); #1; k++;
        end
        checks++;
        if (cpu_dtackn !== 1'b0) begin
            errors++; $display("FAIL overlap dtack: timeout, dtackn=%b need 0", cpu_dtackn);
        end
        release_bus();
    endtask

    task automatic test_ext();
        cfg_write(4'd5, 8'h30);
        cfg_write(4'd4, 8'h9C);
        do_access(8'h30, 1'b1, 3'b101, 5, 8'h04, 1, 5, 1'b0);
        do_access(8'h30, 1'b1, 3'b101, 0, 8'h04, 2, 64, 1'b0);
    endtask

    task automatic test_wp();
        cfg_write(4'd2, 8'hA1);
        cfg_write(4'd3, 8'h10);
        do_access(8'h11, 1'b0, 3'b101, 0, 8'h00, 1, 1, 1'b1);
        do_access(8'h11, 1'b1, 3'b101, 0, 8'h02, 1, 1, 1'b0);
    endtask

    task automatic test_sizes();
        cfg_write(4'd8, 8'h83); cfg_write(4'd9, 8'hE0);    // 2 MB window
        cfg_write(4'd12, 8'h82); cfg_write(4'd13, 8'h60);  // 512 kB window
        do_access(8'hFF, 1'b1, 3'b101, 0, 8'h10, 1, 1, 1'b0);
        do_access(8'h67, 1'b1, 3'b101, 0, 8'h40, 1, 1, 1'b0);
    endtask

    task automatic test_back_to_back();
        int n;
        logic c;
        cfg_write(4'd10, 8'h98); cfg_write(4'd11, 8'h50);  // 6 waits
        @(negedge clk);
        addr = {8'h50, 15'd0}; cpu_rnw = 1'b1; cpu_fc = 3'b101; cpu_asn = 1'b0;
        n = 0;
        while (n < 2) begin
            @(posedge clk); c = cpu_cen; #1;
            if (c) n++;
        end
        checks++;
        if (cpu_dtackn !== 1'b1) begin
            errors++; $display("FAIL abort early dtack: got %b need 1", cpu_dtackn);
        end
        release_bus();
        do_access(8'h50, 1'b1, 3'b101, 0, 8'h20, 1, 7, 1'b0);
        do_access(8'h50, 1'b0, 3'b101, 0, 8'h20, 1, 7, 1'b0);
    endtask

    task automatic test_unmapped();
        for (int r = 0; r < 8; r++) cfg_write(4'(2 * r), 8'h00);
        do_access(8'h77, 1'b1, 3'b101, 0, 8'h00, 2, 64, 1'b0);
    endtask

    task automatic test_iack();
        cfg_write(4'd0, 8'h80);
        do_access(8'h00, 1'b1, 3'b111, 0, 8'h00, 0, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_default_read();
        test_waits();
        test_overlap();
        test_ext();
        test_wp();
        test_sizes();
        test_back_to_back();
        test_unmapped();
        test_iack();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/jts16_region_mapper.md
Name: jts16_region_mapper

Overview:
- Parametrised region decoder and DTACK/BERR generator for 68000-based SEGA boards. It generalises the 315-5195 decode to REGIONS programmable windows.
- Adds per-region enable, 0–6 wait states or external-ack mode, write protection, and a bus-error timeout for unmapped accesses.
- Sits between the main CPU bus and the memory/peripheral chip selects. Its register file is loaded through a byte-wide config port driven by the MCU or CPU front end.

Parameters:
- REGIONS, 8: number of decode windows; 2..16.
- AW, 23: CPU word-address width, addr[AW:1]; top 8 bits addr[AW:AW-7] are compared.
- TIMEOUT, 64: cpu_cen ticks before BERR on an unacknowledged cycle; >=8.
- CAW, $clog2(REGIONS)+1: config address width (derived, do not override).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- cpu_cen  in  1  CPU clock enable; all wait counting is in cen ticks
- addr  in  AW  CPU address [AW:1]
- cpu_asn  in  1  address strobe, active low
- cpu_rnw  in  1  1=read
- cpu_fc  in  3  function code; 3'b111 = interrupt acknowledge
- edack  in  1  external data-ack for regions in ext mode, active high
- cfg_we  in  1  register write strobe, one clk per write
- cfg_addr  in  CAW  register index: even=ctrl(r), odd=base(r), r=cfg_addr[CAW-1:1]
- cfg_din  in  8  register write data
- cfg_dout  out  8  combinational read of register cfg_addr
- active  out  REGIONS  one-hot region select, combinational
- cpu_dtackn  out  1  registered DTACK, active low
- cpu_berrn  out  1  registered bus error, active low
- wp_hit  out  1  one-clk pulse on a write to a protected region

Behaviour:
- Register fields per region r:
  - base[7:0].
  - ctrl[7] = enable, ctrl[5] = write protect.
  - ctrl[4:2] = wait cycles 0–6; 7 = external edack mode.
  - ctrl[1:0] = size: 0 = 64 kB, compare 8 bits; 1 = 128 kB, 7 bits; 2 = 512 kB, 5 bits; 3 = 2 MB, 3 bits. Compare the MSBs of addr top byte against the MSBs of base.
  - ctrl[6] is reserved: reads back as written and has no effect.
- Reset values: all base = 0; ctrl(0) = 8'h80 (enabled, 64 kB, 0 wait); all other ctrl = 0. cpu_dtackn = 1, cpu_berrn = 1, wp_hit = 0, FSM = IDLE. rst overrides a simultaneous cfg_we.
- Decode: region r hits when enabled and compare matches.
  - Lowest hitting index wins; higher indices are masked, so active has at most one bit set.
  - active = 0 when cpu_asn = 1, when cpu_fc = 3'b111, or on a write (cpu_rnw = 0) to a protected winning region.
- cfg_we updates take effect on the next clk. A cycle already in progress keeps its latched wait count and mode.
- FSM:
  - IDLE: on the clk where cpu_asn = 0 and cpu_fc != 7, latch the winner's index, wait count, ext flag, WP and hit/none.
    - If the access is a write to a WP region, pulse wp_hit for 1 clk.
    - Go to WAIT with cnt = wait count and tmo = 0. If no region hit, go to WAIT in miss mode.
    - If cpu_fc = 7, stay in IDLE; this block does not acknowledge interrupt cycles.
  - WAIT: on each cpu_cen, tmo += 1.
    - Internal mode: if cnt = 0, go to ACK; else cnt -= 1. Zero wait therefore asserts DTACK on the first cen after ASn is seen.
    - Ext mode: go to ACK on the first cen with edack = 1.
    - Miss mode and unacknowledged ext mode: when tmo reaches TIMEOUT, go to ERR.
  - ACK: cpu_dtackn = 0 until cpu_asn = 1.
  - ERR: cpu_berrn = 0 until cpu_asn = 1.
  - Any state: cpu_asn = 1 returns the FSM to IDLE, and cpu_dtackn/cpu_berrn deassert on the next clk. This includes ASn rising mid-wait.
- WP writes complete with normal DTACK timing; the write is discarded because active = 0.
- The tmo counter saturates, and ERR holds no matter how long ASn stays low.

Test Plan:
- Reset only: cpu_asn=0, addr top byte 8'h00, read → active=8'h01; cpu_dtackn falls on the 1st cpu_cen; cpu_berrn stays 1.
- ctrl(3)=8'h8C (3 waits), base(3)=8'h40, ctrl(0) disabled; read at addr top 8'h40 → active=8'h08; dtackn low on the 4th cen; ASn high → dtackn=1 one clk later.
- Overlap: regions 1 and 2 both match 8'h20 → active=8'h02; disable region 1 via cfg → active=8'h04 on the next clk.
- Ext mode ctrl(2)=8'h9C; edack rises at the 5th cen → DTACK at the 5th cen. Repeat with edack never raised → berrn low at cen 64, held until ASn high.
- Write protect ctrl(1)=8'hA1, base 8'h10; write to addr top 8'h11 → wp_hit pulse 1 clk, active=0, DTACK at the 1st cen. Read of the same address → active=8'h02, no wp_hit.
- Unmapped address with all regions disabled → active=0, berrn low after 64 cens. cpu_fc=7 with ASn low → active=0, no DTACK, no BERR.
